// File: rtl/axi_lite_master_arbiter_if.sv
// AXI4-Lite M00 bus bundle between the two-client arbiter (master) and the slave register bank.
// Slave address, write and read channels only; no prot signals.
interface axi_lite_master_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_master_arbiter.sv
// Round-robin arbiter letting two clients share one AXI4-Lite slave, one single-beat
// transaction in flight at a time; returns read data and a response error flag per client.
module axi_lite_master_arbiter #(
    parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M00_AXI_ADDR_WIDTH = 4
) (
    input  logic                                m00_axi_aclk,
    input  logic                                m00_axi_areset,
    input  logic [1:0]                          req_valid,
    input  logic [1:0]                          req_write,
    input  logic [2*C_M00_AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*C_M00_AXI_DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                          req_done,
    output logic [1:0]                          req_err,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     req_rdata,
    axi_lite_master_arbiter_if.master           m00_axi
);
    localparam int unsigned DW = C_M00_AXI_DATA_WIDTH;
    localparam int unsigned AW = C_M00_AXI_ADDR_WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;

    // Arbitration: a tie goes to the client that was not served last.
    logic          pick_c;
    logic          pick_write_c;
    logic [AW-1:0] pick_addr_c;
    logic [DW-1:0] pick_wdata_c;
    logic          aw_ok_c;
    logic          w_ok_c;

    assign pick_c       = (&req_valid) ? ~last_grant_q : req_valid[1];
    assign pick_write_c = req_write[pick_c];
    assign pick_addr_c  = pick_c ? req_addr[AW +: AW]  : req_addr[0 +: AW];
    assign pick_wdata_c = pick_c ? req_wdata[DW +: DW] : req_wdata[0 +: DW];

    // An AW or W channel counts as finished once its valid has dropped or it handshakes now.
    assign aw_ok_c = ~awvalid_q | m00_axi.awready;
    assign w_ok_c  = ~wvalid_q  | m00_axi.wready;

    always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
        if (m00_axi_areset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        done_d       = 2'b00;
        err_d        = 2'b00;
        rdata_d      = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d = pick_c;
                    addr_d  = pick_addr_c;
                    wdata_d = pick_wdata_c;
                    if (pick_write_c) begin
                        state_d   = S_WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            S_WADDR: begin
                if (awvalid_q && m00_axi.awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m00_axi.wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_ok_c && w_ok_c) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end
            end

            S_WRESP: begin
                if (m00_axi.bvalid) begin
                    state_d          = S_DONE;
                    bready_d         = 1'b0;
                    done_d[grant_q]  = 1'b1;
                    err_d[grant_q]   = |m00_axi.bresp;
                end
            end

            S_RADDR: begin
                if (m00_axi.arready) begin
                    state_d   = S_RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end

            S_RDATA: begin
                if (m00_axi.rvalid) begin
                    state_d          = S_DONE;
                    rready_d         = 1'b0;
                    rdata_d          = m00_axi.rdata;
                    done_d[grant_q]  = 1'b1;
                    err_d[grant_q]   = |m00_axi.rresp;
                end
            end

            S_DONE: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_done  = done_q;
    assign req_err   = err_q;
    assign req_rdata = rdata_q;

    assign m00_axi.awaddr  = addr_q;
    assign m00_axi.araddr  = addr_q;
    assign m00_axi.wdata   = wdata_q;
    assign m00_axi.wstrb   = '1;
    assign m00_axi.awvalid = awvalid_q;
    assign m00_axi.wvalid  = wvalid_q;
    assign m00_axi.bready  = bready_q;
    assign m00_axi.arvalid = arvalid_q;
    assign m00_axi.rready  = rready_q;
endmodule
